// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control stage: FSM encoding and default timing.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  localparam int unsigned DIV_DEFAULT       = 5000000;
  localparam int unsigned DB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Raw button conditioning: 2-flop synchroniser, stability-count debounce and a
// one-cycle press pulse on the debounced rising edge.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic Clock,
  input  logic Clear,
  input  logic Raw,
  output logic Level,
  output logic Press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stable_cnt;

  always_ff @(posedge Clock) begin
    if (Clear) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= Raw;
      sync2 <= sync1;
    end
  end

  // Level follows sync2 only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      Level      <= 1'b0;
      Press      <= 1'b0;
      stable_cnt <= '0;
    end else begin
      Press <= 1'b0;
      if (sync2 == Level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CW'(DB_CYCLES - 1)) begin
        Level      <= sync2;
        Press      <= sync2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced Start/Stop and Reset buttons drive an
// IDLE/RUN/PAUSED FSM and a prescaler that emits count-enable pulses.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV       = DIV_DEFAULT,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic Clock,
  input  logic Clear,
  input  logic StartStop,
  input  logic RstBtn,
  output logic E,
  output logic CntClr,
  output logic Running
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] TERM = PW'(DIV - 1);

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] prescaler;
  logic          ss_press;
  logic          rst_press;
  logic          ss_level;
  logic          rst_level;
  logic          unused_levels;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_ss_db (
    .Clock (Clock),
    .Clear (Clear),
    .Raw   (StartStop),
    .Level (ss_level),
    .Press (ss_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_rst_db (
    .Clock (Clock),
    .Clear (Clear),
    .Raw   (RstBtn),
    .Level (rst_level),
    .Press (rst_press)
  );

  // Debounced levels are only observed for debug.
  assign unused_levels = ss_level ^ rst_level;

  always_ff @(posedge Clock) begin
    if (Clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Reset button only acts from PAUSED and wins over a simultaneous Start/Stop.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (ss_press) state_nxt = S_RUN;
      S_RUN:    if (ss_press) state_nxt = S_PAUSED;
      S_PAUSED: begin
        if (rst_press)     state_nxt = S_IDLE;
        else if (ss_press) state_nxt = S_RUN;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Running = 1'b0;
    E       = 1'b0;
    Running = (state == S_RUN);
    E       = (state == S_RUN) && (prescaler == TERM);
  end

  // Pausing keeps the partial period so a resume continues where it stopped.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      prescaler <= '0;
    end else begin
      case (state)
        S_RUN:    prescaler <= (prescaler == TERM) ? '0 : prescaler + PW'(1);
        S_PAUSED: prescaler <= prescaler;
        default:  prescaler <= '0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    CntClr <= Clear | ((state == S_PAUSED) && rst_press);
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl (DIV=5, DB_CYCLES=4): expected output
// events are queued by edge number and matched by an independent monitor.
module tb_stopwatch_ctrl;

  localparam int DIV = 5;
  localparam int DB  = 4;
  localparam int EV_CLR = 0;
  localparam int EV_RUN = 1;
  localparam int EV_E   = 2;

  typedef struct {
    int   edge_no;
    int   kind;
    logic val;
  } ev_t;

  logic Clock     = 1'b0;
  logic Clear     = 1'b1;
  logic StartStop = 1'b0;
  logic RstBtn    = 1'b0;
  logic E;
  logic CntClr;
  logic Running;

  int   edge_n   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;
  logic prev_run = 1'b0;
  ev_t  exp_q[$];

  stopwatch_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .StartStop (StartStop),
    .RstBtn    (RstBtn),
    .E         (E),
    .CntClr    (CntClr),
    .Running   (Running)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) edge_n++;

  // Expected events are kept sorted by (edge, kind) so they can be pushed in any order.
  function automatic void expect_ev(input int e, input int k, input logic v);
    ev_t ev;
    int  i;
    ev.edge_no = e;
    ev.kind    = k;
    ev.val     = v;
    i = 0;
    while (i < exp_q.size() && (exp_q[i].edge_no * 4 + exp_q[i].kind) <= (e * 4 + k)) i++;
    exp_q.insert(i, ev);
  endfunction

  function automatic void expect_e_train(input int first, input int last);
    for (int e = first; e <= last; e += DIV) expect_ev(e, EV_E, 1'b1);
  endfunction

  task automatic observe(input int k, input logic v);
    ev_t ev;
    while (exp_q.size() != 0 && exp_q[0].edge_no < edge_n) begin
      ev = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_event: kind=%0d val=%b never seen, required at edge %0d",
               ev.kind, ev.val, ev.edge_no);
    end
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind=%0d val=%b at edge %0d, required none",
               k, v, edge_n);
    end else begin
      ev = exp_q.pop_front();
      if (ev.edge_no != edge_n || ev.kind != k || ev.val !== v) begin
        n_fail++;
        $display("FAIL event_match: got kind=%0d val=%b at edge %0d, required kind=%0d val=%b at edge %0d",
                 k, v, edge_n, ev.kind, ev.val, ev.edge_no);
      end
    end
  endtask

  // Monitor: any CntClr high, Running change or E high is an output event.
  always @(negedge Clock) begin
    if (!done && edge_n >= 1) begin
      if (CntClr !== 1'b0) observe(EV_CLR, CntClr);
      if (Running !== prev_run) begin
        observe(EV_RUN, Running);
        prev_run = Running;
      end
      if (E !== 1'b0) observe(EV_E, E);
    end
  end

  task automatic goto_edge(input int k);
    while (edge_n < k) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Raise the selected buttons just after edge t, drop them just after edge t+n.
  task automatic hold(input int t, input int n, input logic ss, input logic rb);
    goto_edge(t);
    if (ss) StartStop = 1'b1;
    if (rb) RstBtn = 1'b1;
    goto_edge(t + n);
    StartStop = 1'b0;
    RstBtn    = 1'b0;
  endtask

  initial begin
    // Reset held over edges 1..3: CntClr visible after each of them.
    expect_ev(1, EV_CLR, 1'b1);
    expect_ev(2, EV_CLR, 1'b1);
    expect_ev(3, EV_CLR, 1'b1);
    // Start press raised after edge 5 -> RUN at edge 12, E every 5 cycles.
    expect_ev(12, EV_RUN, 1'b1);
    expect_e_train(16, 141);
    // Pause lands at edge 144 with prescaler 2 held.
    expect_ev(144, EV_RUN, 1'b0);
    // Resume at edge 162: first E two cycles later.
    expect_ev(162, EV_RUN, 1'b1);
    expect_e_train(164, 184);
    // Pause press coinciding with terminal count: E at 184, PAUSED at 185.
    expect_ev(185, EV_RUN, 1'b0);
    // Reset button in PAUSED -> IDLE and one CntClr cycle.
    expect_ev(202, EV_CLR, 1'b1);
    // Restart from IDLE: prescaler starts from 0.
    expect_ev(222, EV_RUN, 1'b1);
    expect_e_train(226, 246);
    expect_ev(247, EV_RUN, 1'b0);
    // Both buttons together in PAUSED: reset wins, Running stays low.
    expect_ev(267, EV_CLR, 1'b1);
    // Restart, then Clear sampled on the cycle after the E at 301.
    expect_ev(287, EV_RUN, 1'b1);
    expect_e_train(291, 301);
    expect_ev(302, EV_CLR, 1'b1);
    expect_ev(302, EV_RUN, 1'b0);

    goto_edge(3);
    Clear = 1'b0;
    hold(5,   100, 1'b1, 1'b0);  // long hold: one transition only
    hold(115, 3,   1'b1, 1'b0);  // glitch shorter than DB_CYCLES
    hold(125, 4,   1'b0, 1'b1);  // reset button in RUN is ignored
    hold(137, 4,   1'b1, 1'b0);
    hold(155, 4,   1'b1, 1'b0);
    hold(178, 4,   1'b1, 1'b0);
    hold(195, 4,   1'b0, 1'b1);
    hold(215, 4,   1'b1, 1'b0);
    hold(240, 4,   1'b1, 1'b0);
    hold(260, 4,   1'b1, 1'b1);
    hold(280, 4,   1'b1, 1'b0);
    goto_edge(301);
    Clear = 1'b1;
    goto_edge(302);
    Clear = 1'b0;
    goto_edge(320);
    done = 1'b1;

    while (exp_q.size() != 0) begin
      ev_t ev;
      ev = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missed_event: kind=%0d val=%b never seen, required at edge %0d",
               ev.kind, ev.val, ev.edge_no);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
